sme_sched: RTL

Job scheduler in front of the string-matching engine. Host software loads one string and up to four patterns into local buffers, then pulses `start`. The block replays the string and then one pattern into the engine per match pass, waits for the engine's verdict, and returns one tagged result per pattern through a ready/valid port. Each pass is self-contained: the string is re-sent before every pattern, so no engine state is reused between passes.

---
 rtl/sme_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sme_sched.sv
// sme_sched: buffers one string and up to PAT_SLOTS patterns, replays string+pattern
// into the matching engine once per slot and returns one tagged result per slot.
module sme_sched #(
  parameter int STR_MAX   = 32,
  parameter int PAT_SLOTS = 4,
  parameter int PAT_MAX   = 8,
  parameter int TIMEOUT   = 63
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       str_we,
  input  logic [7:0] str_data,
  input  logic       pat_we,
  input  logic [7:0] pat_data,
  input  logic       pat_last,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [1:0] res_pat_id,
  output logic       res_timeout
);
  localparam int SW  = $clog2(STR_MAX + 1);
  localparam int SA  = $clog2(STR_MAX);
  localparam int PW  = $clog2(PAT_MAX + 1);
  localparam int PA  = $clog2(PAT_MAX);
  localparam int CW  = $clog2(PAT_SLOTS + 1);
  localparam int SLW = $clog2(PAT_SLOTS);
  localparam int TW  = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, REPORT} state_t;
  state_t state;
  logic [7:0] str_buf [STR_MAX];
  logic [7:0] pat_buf [PAT_SLOTS][PAT_MAX];
  logic [PW-1:0] pat_len [PAT_SLOTS];
  logic [SW-1:0] str_len, idx;
  logic [CW-1:0] pat_cnt;
  logic [PW-1:0] pat_fill;
  logic [SLW-1:0] slot;
  logic [TW-1:0] tcnt;
  logic str_full, pat_full, fill_full, pat_ok;
  assign busy      = state != IDLE;
  assign str_full  = str_len == SW'(STR_MAX);
  assign pat_full  = pat_cnt == CW'(PAT_SLOTS);
  assign fill_full = pat_fill == PW'(PAT_MAX);
  assign pat_ok    = state == IDLE && pat_we && !pat_full;
  // Buffer storage carries no reset; validity is tracked by str_len / pat_cnt.
  always_ff @(posedge clk) begin
    if (state == IDLE && str_we && !str_full) str_buf[str_len[SA-1:0]] <= str_data;
    if (pat_ok && !fill_full) pat_buf[pat_cnt[SLW-1:0]][pat_fill[PA-1:0]] <= pat_data;
    if (pat_ok && pat_last) pat_len[pat_cnt[SLW-1:0]] <= pat_fill + PW'(!fill_full);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      str_len       <= '0;
      pat_cnt       <= '0;
      pat_fill      <= '0;
      slot          <= '0;
      idx           <= '0;
      tcnt          <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      res_valid     <= 1'b0;
      res_match     <= 1'b0;
      res_index     <= '0;
      res_pat_id    <= '0;
      res_timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && (str_we || pat_we)) err <= 1'b1;
      case (state)
        IDLE: begin
          if (str_we) begin
            if (str_full) err <= 1'b1;
            else str_len <= str_len + SW'(1);
          end
          if (pat_we) begin
            if (pat_full || fill_full) err <= 1'b1;
            if (!pat_full) begin
              pat_fill <= pat_last ? '0 : pat_fill + PW'(!fill_full);
              if (pat_last) pat_cnt <= pat_cnt + CW'(1);
            end
          end
          if (start) begin
            if (str_len == '0 || pat_cnt == '0) done <= 1'b1;
            else begin
              err          <= 1'b0;
              slot         <= '0;
              state        <= SEND_STR;
              sme_isstring <= 1'b1;
              sme_chardata <= str_buf[0];
              idx          <= SW'(1);
            end
          end
        end
        SEND_STR:
          if (idx == str_len) begin
            sme_isstring <= 1'b0;
            idx          <= SW'(1);
            if (pat_len[slot] == '0) begin
              state        <= WAIT;
              sme_chardata <= '0;
              tcnt         <= '0;
            end else begin
              state         <= SEND_PAT;
              sme_ispattern <= 1'b1;
              sme_chardata  <= pat_buf[slot][0];
            end
          end else begin
            sme_chardata <= str_buf[idx[SA-1:0]];
            idx          <= idx + SW'(1);
          end
        SEND_PAT:
          if (idx == SW'(pat_len[slot])) begin
            state         <= WAIT;
            sme_ispattern <= 1'b0;
            sme_chardata  <= '0;
            tcnt          <= '0;
          end else begin
            sme_chardata <= pat_buf[slot][idx[PA-1:0]];
            idx          <= idx + SW'(1);
          end
        WAIT:
          if (sme_valid || tcnt == TW'(TIMEOUT - 1)) begin
            state       <= REPORT;
            res_valid   <= 1'b1;
            res_pat_id  <= slot;
            res_match   <= sme_valid & sme_match;
            res_index   <= sme_valid ? sme_match_index : '0;
            res_timeout <= !sme_valid;
          end else tcnt <= tcnt + TW'(1);
        REPORT:
          if (res_ready) begin
            res_valid <= 1'b0;
            if (CW'(slot) + CW'(1) == pat_cnt) begin
              state    <= IDLE;
              done     <= 1'b1;
              str_len  <= '0;
              pat_cnt  <= '0;
              pat_fill <= '0;
            end else begin
              slot         <= slot + SLW'(1);
              state        <= SEND_STR;
              sme_isstring <= 1'b1;
              sme_chardata <= str_buf[0];
              idx          <= SW'(1);
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
